// File: rtl/sobel_control_unit.sv
// ---------------------------------------------------------------------------
// sobel_control_unit : sequencer that walks interior pixels, fetches 3x3
// windows, drives the Sobel engine and writes 16-bit results. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sobel_control_unit #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] img_width,
  input  logic [15:0] img_height,
  input  logic [31:0] src_addr,
  input  logic [31:0] dst_addr,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        mem_read_req,
  output logic [31:0] mem_read_addr,
  input  logic        mem_read_ack,
  input  logic [71:0] mem_read_data,
  output logic        mem_write_req,
  output logic [31:0] mem_write_addr,
  output logic [15:0] mem_write_data,
  input  logic        mem_write_ack,
  output logic        ce_valid_in,
  output logic [71:0] ce_pixels_3x3,
  input  logic        ce_valid_out,
  input  logic [15:0] ce_gradient_x,
  input  logic        ce_busy,
  output logic        ce_enable
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_FETCH   = 3'd2,
    S_PROCESS = 3'd3,
    S_WRITE   = 3'd4,
    S_FINISH  = 3'd5,
    S_ERROR   = 3'd6
  } state_t;

  state_t        state_q;
  logic [15:0]   w_q;
  logic [15:0]   h_q;
  logic [15:0]   x_q;
  logic [15:0]   y_q;
  logic [31:0]   rd_row_q;
  logic [TW-1:0] tmr_q;
  logic          issued_q;
  logic          busy_q;
  logic          done_q;
  logic          error_q;
  logic          rd_req_q;
  logic [31:0]   rd_addr_q;
  logic          wr_req_q;
  logic [31:0]   wr_addr_q;
  logic [15:0]   wr_data_q;
  logic          ce_vin_q;
  logic [71:0]   ce_pix_q;
  logic          ce_en_q;

  logic w_waiting;
  logic w_wait_done;
  logic w_abort;

  assign w_waiting   = (state_q == S_FETCH) || (state_q == S_PROCESS) || (state_q == S_WRITE);
  assign w_wait_done = ((state_q == S_FETCH)   && mem_read_ack) ||
                       ((state_q == S_PROCESS) && issued_q && ce_valid_out) ||
                       ((state_q == S_WRITE)   && mem_write_ack);
  assign w_abort     = w_waiting && !w_wait_done && (tmr_q == TMR_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      w_q       <= '0;
      h_q       <= '0;
      x_q       <= '0;
      y_q       <= '0;
      rd_row_q  <= '0;
      tmr_q     <= '0;
      issued_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      rd_req_q  <= 1'b0;
      rd_addr_q <= '0;
      wr_req_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      ce_vin_q  <= 1'b0;
      ce_pix_q  <= '0;
      ce_en_q   <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      ce_vin_q <= 1'b0;
      if (w_abort) begin
        rd_req_q <= 1'b0;
        wr_req_q <= 1'b0;
        ce_en_q  <= 1'b0;
        error_q  <= 1'b1;
        tmr_q    <= '0;
        state_q  <= S_ERROR;
      end else begin
        if (w_waiting) tmr_q <= w_wait_done ? '0 : tmr_q + 1'b1;
        case (state_q)
          S_IDLE: begin
            if (start) begin
              busy_q <= 1'b1;
              if (img_width >= 16'd3 && img_height >= 16'd3) begin
                w_q       <= img_width;
                h_q       <= img_height;
                rd_row_q  <= src_addr;
                wr_addr_q <= dst_addr;
                error_q   <= 1'b0;
                ce_en_q   <= 1'b1;
                state_q   <= S_SETUP;
              end else begin
                error_q <= 1'b1;
                state_q <= S_ERROR;
              end
            end
          end
          S_SETUP: begin
            x_q       <= '0;
            y_q       <= '0;
            rd_addr_q <= rd_row_q;
            rd_req_q  <= 1'b1;
            tmr_q     <= '0;
            state_q   <= S_FETCH;
          end
          S_FETCH: begin
            if (mem_read_ack) begin
              ce_pix_q <= mem_read_data;
              rd_req_q <= 1'b0;
              issued_q <= 1'b0;
              state_q  <= S_PROCESS;
            end
          end
          S_PROCESS: begin
            if (w_wait_done) begin
              wr_data_q <= ce_gradient_x;
              wr_req_q  <= 1'b1;
              state_q   <= S_WRITE;
            end else if (!issued_q && !ce_busy) begin
              ce_vin_q <= 1'b1;
              issued_q <= 1'b1;
            end
          end
          S_WRITE: begin
            if (mem_write_ack) begin
              wr_req_q  <= 1'b0;
              // Results are dense row-major, so the write address just advances by one word.
              wr_addr_q <= wr_addr_q + 32'd2;
              if (x_q != w_q - 16'd3) begin
                x_q       <= x_q + 16'd1;
                rd_addr_q <= rd_addr_q + 32'd1;
                rd_req_q  <= 1'b1;
                state_q   <= S_FETCH;
              end else if (y_q != h_q - 16'd3) begin
                x_q       <= '0;
                y_q       <= y_q + 16'd1;
                rd_row_q  <= rd_row_q + {16'd0, w_q};
                rd_addr_q <= rd_row_q + {16'd0, w_q};
                rd_req_q  <= 1'b1;
                state_q   <= S_FETCH;
              end else begin
                done_q  <= 1'b1;
                state_q <= S_FINISH;
              end
            end
          end
          S_FINISH: begin
            busy_q  <= 1'b0;
            ce_en_q <= 1'b0;
            state_q <= S_IDLE;
          end
          S_ERROR: begin
            busy_q  <= 1'b0;
            ce_en_q <= 1'b0;
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;
  assign mem_read_req   = rd_req_q;
  assign mem_read_addr  = rd_addr_q;
  assign mem_write_req  = wr_req_q;
  assign mem_write_addr = wr_addr_q;
  assign mem_write_data = wr_data_q;
  assign ce_valid_in    = ce_vin_q;
  assign ce_pixels_3x3  = ce_pix_q;
  assign ce_enable      = ce_en_q;

endmodule

`default_nettype wire

// File: tb/tb_sobel_control_unit.sv
// ---------------------------------------------------------------------------
// tb_sobel_control_unit : directed + randomized bench with memory/engine
// responders and a pixel-walk reference model. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sobel_control_unit;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] img_width = '0;
  logic [15:0] img_height = '0;
  logic [31:0] src_addr = '0;
  logic [31:0] dst_addr = '0;
  logic        busy, done, error;
  logic        mem_read_req;
  logic [31:0] mem_read_addr;
  logic        mem_read_ack = 1'b0;
  logic [71:0] mem_read_data = '0;
  logic        mem_write_req;
  logic [31:0] mem_write_addr;
  logic [15:0] mem_write_data;
  logic        mem_write_ack = 1'b0;
  logic        ce_valid_in;
  logic [71:0] ce_pixels_3x3;
  logic        ce_valid_out = 1'b0;
  logic [15:0] ce_gradient_x = '0;
  logic        ce_busy = 1'b0;
  logic        ce_enable;

  sobel_control_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .img_width(img_width), .img_height(img_height),
    .src_addr(src_addr), .dst_addr(dst_addr),
    .busy(busy), .done(done), .error(error),
    .mem_read_req(mem_read_req), .mem_read_addr(mem_read_addr),
    .mem_read_ack(mem_read_ack), .mem_read_data(mem_read_data),
    .mem_write_req(mem_write_req), .mem_write_addr(mem_write_addr),
    .mem_write_data(mem_write_data), .mem_write_ack(mem_write_ack),
    .ce_valid_in(ce_valid_in), .ce_pixels_3x3(ce_pixels_3x3),
    .ce_valid_out(ce_valid_out), .ce_gradient_x(ce_gradient_x),
    .ce_busy(ce_busy), .ce_enable(ce_enable)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Environment configuration
  int          rd_lat = 0, wr_lat = 0, ce_lat = 0;
  bit          rd_en = 1'b1, wr_en = 1'b1, busy_rand = 1'b0;
  int          mem_mode = 0, grad_mode = 0;
  int unsigned seed = 0;

  // Monitor results
  logic [31:0] rd_q[$];
  logic [31:0] wa_q[$];
  logic [15:0] wd_q[$];
  logic [71:0] px_q[$];
  int done_cnt = 0, vin_long = 0, req_cycles = 0, busy_cycles = 0;
  int rdreq_cycles = 0, stab_err = 0, busy_viol = 0;

  function automatic logic [71:0] mem_fn(input logic [31:0] a);
    logic [71:0] r;
    r = '0;
    if (mem_mode == 1) r = {8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90};
    else for (int k = 0; k < 9; k++) r[71-8*k -: 8] = 8'(a * 13 + 32'(k * 37) + seed);
    return r;
  endfunction

  function automatic logic [15:0] grad_fn(input logic [71:0] p);
    if (grad_mode == 1) return 16'd123;
    return 16'(({8'd0, p[71:64]} * 16'd3) + ({8'd0, p[39:32]} * 16'd5)) ^ p[15:0];
  endfunction

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory read responder
  initial begin
    int cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (!mem_read_req || !rd_en || mem_read_ack) begin
        mem_read_ack = 1'b0; cnt = 0;
        mem_read_data = 72'({$urandom(), $urandom(), $urandom()});
      end else if (cnt >= rd_lat) begin
        mem_read_ack = 1'b1; mem_read_data = mem_fn(mem_read_addr);
      end else begin
        cnt++;
        mem_read_data = 72'({$urandom(), $urandom(), $urandom()});
      end
    end
  end

  // Memory write responder
  initial begin
    int cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (!mem_write_req || !wr_en || mem_write_ack) begin
        mem_write_ack = 1'b0; cnt = 0;
      end else if (cnt >= wr_lat) mem_write_ack = 1'b1;
      else cnt++;
    end
  end

  // Engine model
  initial begin
    bit          pend = 1'b0;
    int          cnt = 0;
    logic [71:0] px = '0;
    forever begin
      @(posedge clk); #1;
      ce_valid_out = 1'b0;
      ce_busy = busy_rand ? ($urandom_range(0, 3) == 0) : 1'b0;
      if (ce_valid_in) begin pend = 1'b1; cnt = ce_lat; px = ce_pixels_3x3; end
      if (pend) begin
        if (cnt == 0) begin ce_valid_out = 1'b1; ce_gradient_x = grad_fn(px); pend = 1'b0; end
        else cnt--;
      end
    end
  end

  // Observer
  initial begin
    bit          prev_vin = 1'b0, prev_rreq = 1'b0, prev_rack = 1'b0, prev_cbusy = 1'b0;
    logic [31:0] prev_raddr = '0;
    forever begin
      @(negedge clk);
      if (mem_read_req && mem_read_ack) rd_q.push_back(mem_read_addr);
      if (mem_write_req && mem_write_ack) begin
        wa_q.push_back(mem_write_addr); wd_q.push_back(mem_write_data);
      end
      if (ce_valid_in) begin
        px_q.push_back(ce_pixels_3x3);
        if (prev_vin) vin_long++;
        if (prev_cbusy) busy_viol++;
      end
      if (done) done_cnt++;
      if (mem_read_req || mem_write_req || ce_valid_in) req_cycles++;
      if (busy) busy_cycles++;
      if (mem_read_req) rdreq_cycles++;
      if (prev_rreq && !prev_rack && mem_read_req && mem_read_addr != prev_raddr) stab_err++;
      prev_vin = ce_valid_in; prev_rreq = mem_read_req; prev_rack = mem_read_ack;
      prev_raddr = mem_read_addr; prev_cbusy = ce_busy;
    end
  end

  task automatic clear_mon();
    rd_q.delete(); wa_q.delete(); wd_q.delete(); px_q.delete();
    done_cnt = 0; vin_long = 0; req_cycles = 0; busy_cycles = 0;
    rdreq_cycles = 0; stab_err = 0; busy_viol = 0;
  endtask

  task automatic pulse_start(input int w, input int h, input logic [31:0] s, input logic [31:0] d);
    @(negedge clk);
    img_width = 16'(w); img_height = 16'(h); src_addr = s; dst_addr = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int maxc, input string tag);
    int n = 0;
    while (busy && n < maxc) begin @(negedge clk); n++; end
    chk(tag, {71'd0, busy}, 72'd0);
    if (busy) begin
      rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_model(input int w, input int h, input logic [31:0] s, input logic [31:0] d,
                             input string tag);
    int n = (w - 2) * (h - 2);
    int k = 0;
    logic [31:0] ea, ew;
    chk({tag, "_nrd"}, 72'(rd_q.size()), 72'(n));
    chk({tag, "_nwr"}, 72'(wa_q.size()), 72'(n));
    chk({tag, "_nstrobe"}, 72'(px_q.size()), 72'(n));
    chk({tag, "_done"}, 72'(done_cnt), 72'd1);
    chk({tag, "_err"}, {71'd0, error}, 72'd0);
    chk({tag, "_proto"}, 72'(vin_long + stab_err + busy_viol), 72'd0);
    for (int y = 0; y < h - 2; y++) begin
      for (int x = 0; x < w - 2; x++) begin
        ea = s + 32'(y) * 32'(w) + 32'(x);
        ew = d + 32'(2 * (y * (w - 2) + x));
        if (k < rd_q.size()) chk({tag, "_raddr"}, 72'(rd_q[k]), 72'(ea));
        if (k < px_q.size()) chk({tag, "_window"}, px_q[k], mem_fn(ea));
        if (k < wa_q.size()) chk({tag, "_waddr"}, 72'(wa_q[k]), 72'(ew));
        if (k < wd_q.size()) chk({tag, "_wdata"}, 72'(wd_q[k]), 72'(grad_fn(mem_fn(ea))));
        k++;
      end
    end
  endtask

  task automatic run_job(input int w, input int h, input logic [31:0] s, input logic [31:0] d,
                         input bit mid_start, input string tag);
    clear_mon();
    pulse_start(w, h, s, d);
    chk({tag, "_err_clr"}, {71'd0, error}, 72'd0);
    if (mid_start) begin
      repeat (7) @(negedge clk);
      img_width = 16'd9; img_height = 16'd9; src_addr = 32'h5555; dst_addr = 32'h7777; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_idle(4000, {tag, "_busy_end"});
    check_model(w, h, s, d, tag);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ctrl", 72'({busy, done, error, mem_read_req, mem_write_req, ce_valid_in, ce_enable}), 72'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_ctrl", 72'({busy, done, error, mem_read_req, mem_write_req, ce_valid_in, ce_enable}), 72'd0);
    chk("idle_addr", 72'({mem_read_addr, mem_write_addr}), 72'd0);

    // Basic 4x4 job with fixed window and constant gradient
    rd_lat = 1; wr_lat = 1; ce_lat = 2; mem_mode = 1; grad_mode = 1;
    run_job(4, 4, 32'h1000, 32'h2000, 1'b0, "t1");

    // Degenerate sizes
    clear_mon();
    pulse_start(2, 32, 32'h0, 32'h0);
    wait_idle(10, "t3_busy_end");
    chk("t3_err", {71'd0, error}, 72'd1);
    chk("t3_noreq", 72'(req_cycles + done_cnt), 72'd0);
    chk("t3_busy_len", {71'd0, (busy_cycles >= 1 && busy_cycles <= 2)}, 72'd1);
    clear_mon();
    pulse_start(10, 1, 32'h0, 32'h0);
    wait_idle(10, "t3b_busy_end");
    chk("t3b_err", {71'd0, error}, 72'd1);
    chk("t3b_noreq", 72'(req_cycles), 72'd0);
    mem_mode = 0; grad_mode = 0; seed = $urandom;
    run_job(5, 3, 32'h400, 32'h800, 1'b0, "t3c");

    // Start ignored while busy
    run_job(4, 4, 32'h3000, 32'h4000, 1'b1, "t4");

    // Read timeout
    rd_en = 1'b0;
    clear_mon();
    pulse_start(4, 4, 32'h100, 32'h200);
    wait_idle(200, "t5_busy_end");
    chk("t5_req_len", 72'(rdreq_cycles), 72'(TMO));
    chk("t5_err", {71'd0, error}, 72'd1);
    chk("t5_done", 72'(done_cnt), 72'd0);
    chk("t5_reqs_low", 72'({mem_read_req, mem_write_req, ce_enable}), 72'd0);
    rd_en = 1'b1;

    // Asynchronous reset during WRITE
    wr_en = 1'b0;
    clear_mon();
    pulse_start(4, 4, 32'h900, 32'hA00);
    for (int n = 0; n < 100 && !mem_write_req; n++) @(negedge clk);
    chk("t6_in_write", {71'd0, mem_write_req}, 72'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_ctrl", 72'({busy, done, error, mem_read_req, mem_write_req, ce_valid_in, ce_enable}), 72'd0);
    chk("t6_rst_data", 72'({mem_write_addr, mem_write_data}), 72'd0);
    @(negedge clk);
    rst_n = 1'b1; wr_en = 1'b1;
    run_job(3, 3, 32'hB00, 32'hC00, 1'b0, "t6");

    // Randomized jobs, including address wrap-around
    busy_rand = 1'b1;
    for (int i = 0; i < 6; i++) begin
      int w, h;
      logic [31:0] s, d;
      w = $urandom_range(3, 7); h = $urandom_range(3, 6);
      s = (i == 0) ? 32'hFFFF_FFF0 : $urandom;
      d = (i == 1) ? 32'hFFFF_FFFA : $urandom;
      rd_lat = $urandom_range(0, 4); wr_lat = $urandom_range(0, 4); ce_lat = $urandom_range(0, 4);
      seed = $urandom;
      run_job(w, h, s, d, 1'b0, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sobel_control_unit.md
Name: sobel_control_unit

Overview:
Sequencer for the Sobel accelerator. After a start pulse it walks every interior pixel of a W×H 8-bit image. For each pixel it fetches the 3×3 window from the memory interface, hands the window to the Sobel compute engine, and writes the 16-bit gradient result to the destination buffer. It sits between the bus/register front-end (start, sizes, addresses, status) and the memory port and compute engine.

Parameters:
TIMEOUT_CYCLES, 1024, maximum cycles spent waiting for any single mem_read_ack, ce_valid_out or mem_write_ack before entering ERROR.

Ports:
clk  in  1  clock; all logic on its rising edge
rst_n  in  1  reset; asynchronous, active-low
start  in  1  one-cycle request to begin; sampled only in IDLE
img_width  in  16  image width W in pixels
img_height  in  16  image height H in pixels
src_addr  in  32  byte address of source pixel (0,0)
dst_addr  in  32  byte address of first result
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on completion
error  out  1  sticky error flag
mem_read_req  out  1  window read request (level)
mem_read_addr  out  32  window top-left byte address
mem_read_ack  in  1  read complete; mem_read_data valid in this cycle
mem_read_data  in  72  nine 8-bit pixels, p0 in [71:64] … p8 in [7:0], row-major
mem_write_req  out  1  result write request (level)
mem_write_addr  out  32  result byte address
mem_write_data  out  16  result value
mem_write_ack  in  1  write complete
ce_valid_in  out  1  one-cycle strobe; ce_pixels_3x3 valid
ce_pixels_3x3  out  72  window passed unchanged to the engine
ce_valid_out  in  1  engine result valid
ce_gradient_x  in  16  engine result
ce_busy  in  1  engine busy; ce_valid_in is not issued while high
ce_enable  out  1  engine enable; high in SETUP through FINISH

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0, all counters and latched values 0, error cleared.
- States: IDLE, SETUP, FETCH, PROCESS, WRITE, FINISH, ERROR.
- IDLE:
  - start=1 with W≥3 and H≥3: latch all inputs, clear error, go to SETUP.
  - start=1 with W<3 or H<3: set error, go to ERROR.
  - start while busy: ignored.
- SETUP (1 cycle): x=0, y=0, go to FETCH.
- FETCH:
  - Assert mem_read_req with mem_read_addr = src + y*W + x (32-bit arithmetic, truncating).
  - Hold req and addr stable until a cycle in which mem_read_ack=1 is sampled.
  - On that edge: capture mem_read_data, drop req, go to PROCESS.
- PROCESS:
  - When ce_busy=0, drive ce_valid_in=1 for exactly one cycle with the captured window on ce_pixels_3x3.
  - Then wait for ce_valid_out=1, capture ce_gradient_x, go to WRITE.
- WRITE:
  - Assert mem_write_req with mem_write_addr = dst + 2*(y*(W-2)+x) and mem_write_data = the captured result.
  - Hold until mem_write_ack=1 is sampled, then drop req.
  - If x<W-3: x++, go to FETCH. Else if y<H-3: x=0, y++, go to FETCH. Else go to FINISH.
- FINISH (1 cycle): done=1, then IDLE; busy falls in the same transition.
- Timeout: each wait (read ack, engine result, write ack) has a cycle counter reset on entry. Reaching TIMEOUT_CYCLES drops all requests, sets error, goes to ERROR.
- ERROR (1 cycle) then IDLE. error stays 1 until the next accepted start or reset. done is not pulsed.
- Output count: (W-2)*(H-2). Per-pixel latency: ≥ 1 read-handshake cycle + engine latency + 1 write-handshake cycle.
- Unexpected ack/ce_valid_out outside its wait state: ignored.
- Reset mid-operation: immediate abort to IDLE; requests drop asynchronously.

Test Plan:
1. W=H=4, src=0x1000, dst=0x2000, memory acks 1 cycle after req, engine returns 123 two cycles after ce_valid_in -> reads at 0x1000, 0x1001, 0x1004, 0x1005; writes at 0x2000, 0x2002, 0x2004, 0x2006 with data 123; one done pulse; busy low afterwards; error=0.
2. Window check: mem_read_data = {10,20,…,90} -> ce_pixels_3x3 equals it bit-exact on the ce_valid_in cycle; ce_valid_in high exactly one cycle per pixel.
3. start with W=2, H=32 -> error=1, no mem or ce requests, busy high ≤2 cycles; a subsequent valid start clears error.
4. Second start pulse mid-run -> ignored: output count still 4; x,y progression unchanged.
5. mem_read_ack tied 0 with TIMEOUT_CYCLES=16 -> mem_read_req held 16 cycles, then error=1, req dropped, state returns to IDLE, no done.
6. rst_n driven low during WRITE -> all outputs 0 immediately; after release, a new start with W=H=3 yields exactly one write at dst and a done pulse.
